xmuladd_vec: RTL and testbench
==============================

// Module: xmuladd_vec
// PURPOSE
//  Parametrised successor of the single-lane multiply-accumulate unit. LANES independent signed
//  MAC lanes share one control path. Each lane accumulates ACC_LEN valid products per block and
//  emits a rounded, optionally saturated, result per block. Runs N_BLK blocks per start.
//  Sits in the versat datapath as a flow-consuming functional unit with a valid handshake.
// PARAMETERS
//  DATA_W   32  operand and output width per lane (signed)
//  LANES    4   number of parallel MAC lanes
//  GUARD_W  8   accumulator guard bits; ACC_W = 2*DATA_W+GUARD_W
//  CNT_W    10  width of acc_len / n_blk counters
//  SHIFT_W  6   width of output shift field
// PORTS
//  clk       in   1              clock
//  rst       in   1              async active-high reset
//  start     in   1              pulse: sample config, begin run (ignored while busy)
//  opcode    in   2              0=MACC, 1=MSUB, 2=MUL (no accumulation; every sample emits)
//  acc_len   in   CNT_W          valid samples per block (0 => start ignored)
//  n_blk     in   CNT_W          blocks per run (0 => start ignored)
//  shift     in   SHIFT_W        arithmetic right shift of result, round-half-up
//  sat_en    in   1              1: saturate to DATA_W signed range; 0: truncate
//  in_valid  in   1              operands valid this cycle
//  a_in      in   LANES*DATA_W   lane i operand at [i*DATA_W +: DATA_W]
//  b_in      in   LANES*DATA_W   same packing as a_in
//  busy      out  1              run in progress; samples accepted only when busy&in_valid
//  out_valid out  1              out_data holds a block result this cycle
//  out_data  out  LANES*DATA_W   per-lane results, same packing
//  done      out  1              1-cycle pulse with out_valid of the last block
// BEHAVIOUR
//  - Reset: busy=0, out_valid=0, done=0, out_data=0, counters=0, accumulators=0, pipe valids=0.
//  - FSM IDLE->RUN on start with acc_len!=0 and n_blk!=0; config latched on that edge.
//    RUN->DRAIN when last sample of last block is accepted; DRAIN->IDLE when done pulses.
//    busy=1 in RUN only; in_valid ignored in IDLE/DRAIN. start ignored outside IDLE.
//  - Pipeline: S1 register a/b, S2 product (2*DATA_W), S3 accumulate (ACC_W), S4 round/shift/sat.
//    Sample accepted at cycle t -> its contribution visible on out_data at t+4 when it closes a block.
//  - First sample of each block (sample counter==0) loads acc with +/-product (flag piped to S3);
//    later samples add (MACC) or subtract (MSUB). MUL: every sample is a 1-sample block.
//  - in_valid gaps stall nothing: bubbles flow through with valid=0, acc holds.
//  - Sample counter wraps to 0 at acc_len-1 and increments block counter; block counter
//    reaching n_blk-1 with wrap ends RUN.
//  - S4: r = (acc + (shift?1<<(shift-1):0)) >>> shift, computed in ACC_W+1 bits (no overflow).
//    sat_en: clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; else keep low DATA_W bits.
//  - out_valid/out_data registered; out_data holds last value when out_valid=0.
//  - Reset mid-run: all state cleared immediately, no done, no partial result emitted.
//  - start in same cycle as done: ignored (FSM still DRAIN); next cycle accepted.
// STRUCTURE
//  - xmuladddefs.vh: add MULADD_MUL opcode and MULADD_OP_W; reuse MULADD_MACC/MULADD_MSUB.
//  - Sub-module xmuladd_lane (S1-S4 datapath of one lane, ld/valid inputs), generated LANES times;
//    xmuladd_vec holds FSM, counters and valid/ld/last pipeline.
// TESTING
//  - LANES=4, MACC, acc_len=3, n_blk=1, shift=0, a=b={1,2,3,-4} x3 back-to-back -> one out_valid
//    4 cycles after 3rd sample, lanes {3,12,27,48}, done same cycle, busy low after last accept.
//  - MSUB, acc_len=2, n_blk=2, a=5,b=2 each sample with in_valid gaps -> two results -20,-20;
//    done only on second; gaps do not change values.
//  - Rounding: MUL, a=7,b=1, shift=1 -> 4; a=-7,b=1, shift=1 -> -3; shift=0 -> 7 / -7.
//  - Saturation DATA_W=16: MACC acc_len=4, a=b=32767 -> sat_en=1 gives 32767; sat_en=0 gives
//    low 16 bits of 4*32767^2; negative case clamps to -32768.
//  - Control: acc_len=0 start -> busy stays 0; start while busy ignored; rst asserted mid-block
//    -> out_valid/done never pulse, new run afterwards gives correct first-block result.
//  - Random: LANES=3 random ops/modes/in_valid vs reference model, compare every out_valid.

Source files
------------

// File: rtl/xmuladd_vec_pkg.sv
// xmuladd_vec_pkg: shared opcode/state encodings for the vector multiply-accumulate unit.
// Rev 1.0
`default_nettype none

package xmuladd_vec_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_MACC = 2'd0,
    OP_MSUB = 2'd1,
    OP_MUL  = 2'd2
  } opcode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/xmuladd_vec_if.sv
// xmuladd_vec_if: control, operand and result bundle of the vector MAC unit.
// Rev 1.0
`default_nettype none

interface xmuladd_vec_if
  import xmuladd_vec_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int LANES   = 4,
  parameter int CNT_W   = 10,
  parameter int SHIFT_W = 6
);
  logic                    start;
  logic [OP_W-1:0]         opcode;
  logic [CNT_W-1:0]        acc_len;
  logic [CNT_W-1:0]        n_blk;
  logic [SHIFT_W-1:0]      shift;
  logic                    sat_en;
  logic                    in_valid;
  logic [LANES*DATA_W-1:0] a_in;
  logic [LANES*DATA_W-1:0] b_in;
  logic                    busy;
  logic                    out_valid;
  logic [LANES*DATA_W-1:0] out_data;
  logic                    done;

  modport master (
    output start, opcode, acc_len, n_blk, shift, sat_en, in_valid, a_in, b_in,
    input  busy, out_valid, out_data, done
  );

  modport slave (
    input  start, opcode, acc_len, n_blk, shift, sat_en, in_valid, a_in, b_in,
    output busy, out_valid, out_data, done
  );
endinterface

`default_nettype wire

// File: rtl/xmuladd_lane.sv
// xmuladd_lane: one signed MAC lane (operand reg, product, accumulate, round/shift/saturate).
// Rev 1.0
`default_nettype none

module xmuladd_lane #(
  parameter int DATA_W  = 32,
  parameter int GUARD_W = 8,
  parameter int SHIFT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cap,
  input  logic [DATA_W-1:0]  a,
  input  logic [DATA_W-1:0]  b,
  input  logic               acc_en,
  input  logic               acc_ld,
  input  logic               acc_sub,
  input  logic               emit,
  input  logic [SHIFT_W-1:0] shift,
  input  logic               sat_en,
  output logic [DATA_W-1:0]  res
);
  localparam int ACC_W = 2*DATA_W + GUARD_W;
  localparam int R_W   = ACC_W + 1;
  localparam logic signed [R_W-1:0] SAT_MAX = {{(R_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [R_W-1:0] SAT_MIN = {{(R_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [DATA_W-1:0]   a_q, b_q;
  logic signed [2*DATA_W-1:0] prod_q;
  logic signed [ACC_W-1:0]    acc_q, prod_x;
  logic signed [R_W-1:0]      acc_x, rnd, sum, r;
  logic [DATA_W-1:0]          res_d;

  always_comb begin
    prod_x = {{GUARD_W{prod_q[2*DATA_W-1]}}, prod_q};
    acc_x  = {acc_q[ACC_W-1], acc_q};
    rnd    = (shift == '0) ? '0 : (R_W'(1) << (shift - 1'b1));
    // One extra bit keeps the rounding increment from overflowing the accumulator range
    sum    = acc_x + rnd;
    r      = sum >>> shift;
    if (!sat_en)
      res_d = r[DATA_W-1:0];
    else if (r > SAT_MAX)
      res_d = SAT_MAX[DATA_W-1:0];
    else if (r < SAT_MIN)
      res_d = SAT_MIN[DATA_W-1:0];
    else
      res_d = r[DATA_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      prod_q <= '0;
      acc_q  <= '0;
      res    <= '0;
    end else begin
      if (cap) begin
        a_q <= a;
        b_q <= b;
      end
      prod_q <= (2*DATA_W)'(a_q) * (2*DATA_W)'(b_q);
      if (acc_en) begin
        if (acc_ld)
          acc_q <= acc_sub ? -prod_x : prod_x;
        else
          acc_q <= acc_sub ? acc_q - prod_x : acc_q + prod_x;
      end
      if (emit)
        res <= res_d;
    end
  end
endmodule

`default_nettype wire

// File: rtl/xmuladd_vec.sv
// xmuladd_vec: LANES parallel signed MAC lanes sharing one block/run controller.
// Rev 1.0
`default_nettype none

module xmuladd_vec
  import xmuladd_vec_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int LANES   = 4,
  parameter int GUARD_W = 8,
  parameter int CNT_W   = 10,
  parameter int SHIFT_W = 6
) (
  input logic          clk,
  input logic          rst,
  xmuladd_vec_if.slave bus
);
  state_t             state, state_nxt;
  opcode_t            op_q;
  logic [CNT_W-1:0]   len_q, nblk_q, samp_q, blk_q;
  logic [SHIFT_W-1:0] shift_q;
  logic               sat_q;
  logic               start_ok, accept, is_mul, blk_end, run_end;
  logic               v1, ld1, last1, fin1;
  logic               v2, ld2, last2, fin2;
  logic               v3, fin3;
  logic               out_valid_q, done_q;
  logic [LANES*DATA_W-1:0] lane_res;

  assign start_ok = (state == ST_IDLE) && bus.start && (bus.acc_len != '0) && (bus.n_blk != '0);
  assign accept   = (state == ST_RUN) && bus.in_valid;
  assign is_mul   = (op_q == OP_MUL);
  // MUL treats every sample as a complete block
  assign blk_end  = is_mul || (samp_q == len_q - 1'b1);
  assign run_end  = blk_end && (blk_q == nblk_q - 1'b1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start_ok)          state_nxt = ST_RUN;
      ST_RUN:   if (accept && run_end) state_nxt = ST_DRAIN;
      ST_DRAIN: if (done_q)            state_nxt = ST_IDLE;
      default:                         state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= OP_MACC;
      len_q   <= '0;
      nblk_q  <= '0;
      shift_q <= '0;
      sat_q   <= 1'b0;
      samp_q  <= '0;
      blk_q   <= '0;
    end else if (start_ok) begin
      op_q    <= opcode_t'(bus.opcode);
      len_q   <= bus.acc_len;
      nblk_q  <= bus.n_blk;
      shift_q <= bus.shift;
      sat_q   <= bus.sat_en;
      samp_q  <= '0;
      blk_q   <= '0;
    end else if (accept) begin
      if (blk_end) begin
        samp_q <= '0;
        blk_q  <= run_end ? '0 : blk_q + 1'b1;
      end else begin
        samp_q <= samp_q + 1'b1;
      end
    end
  end

  // Per-sample flags travel alongside the lane datapath so each stage sees its own sample's role
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0; ld1 <= 1'b0; last1 <= 1'b0; fin1 <= 1'b0;
      v2 <= 1'b0; ld2 <= 1'b0; last2 <= 1'b0; fin2 <= 1'b0;
      v3 <= 1'b0; fin3 <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      v1    <= accept;
      ld1   <= is_mul || (samp_q == '0);
      last1 <= accept && blk_end;
      fin1  <= accept && run_end;
      v2    <= v1;
      ld2   <= ld1;
      last2 <= v1 && last1;
      fin2  <= v1 && fin1;
      v3    <= v2 && last2;
      fin3  <= v2 && fin2;
      out_valid_q <= v3;
      done_q      <= v3 && fin3;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    xmuladd_lane #(
      .DATA_W  (DATA_W),
      .GUARD_W (GUARD_W),
      .SHIFT_W (SHIFT_W)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .cap     (accept),
      .a       (bus.a_in[i*DATA_W +: DATA_W]),
      .b       (bus.b_in[i*DATA_W +: DATA_W]),
      .acc_en  (v2),
      .acc_ld  (ld2),
      .acc_sub (op_q == OP_MSUB),
      .emit    (v3),
      .shift   (shift_q),
      .sat_en  (sat_q),
      .res     (lane_res[i*DATA_W +: DATA_W])
    );
  end

  assign bus.busy      = (state == ST_RUN);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = lane_res;
  assign bus.done      = done_q;
endmodule

`default_nettype wire

// File: tb/tb_xmuladd_vec.sv
// tb_xmuladd_vec: directed and randomized checks of xmuladd_vec against a block-level model.
// Rev 1.0
`default_nettype none

module tb_xmuladd_vec;
  localparam int DW = 16;
  localparam int LN = 4;
  localparam int CW = 10;
  localparam int SW = 6;
  localparam longint MAXV = (longint'(1) <<< (DW-1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (DW-1));

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  xmuladd_vec_if #(.DATA_W(DW), .LANES(LN), .CNT_W(CW), .SHIFT_W(SW)) bus ();

  xmuladd_vec #(.DATA_W(DW), .LANES(LN), .GUARD_W(8), .CNT_W(CW), .SHIFT_W(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [LN*DW-1:0] data;
    logic             done;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int n_tests = 0;
  int n_fail  = 0;
  logic signed [DW-1:0] a_fix [LN];
  logic signed [DW-1:0] b_fix [LN];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Block result from the arithmetic definition: round-half-up shift, then clamp or wrap
  function automatic logic [DW-1:0] post(input longint acc, input int sh, input bit sat);
    longint r;
    r = acc;
    if (sh > 0) r += longint'(1) <<< (sh - 1);
    r = r >>> sh;
    if (sat && r > MAXV) r = MAXV;
    else if (sat && r < MINV) r = MINV;
    return r[DW-1:0];
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", bus.out_valid, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_data", bus.out_data, mon_e.data);
          check("done_flag", bus.done, mon_e.done);
        end
      end else if (bus.done) begin
        check("done_without_out_valid", bus.done, 0);
      end
    end
  end

  task automatic do_run(input int op, input int len, input int nblk, input int sh, input bit sat,
                        input int gap_max, input bit rnd_data, input bit poke, input bit lat);
    int spb;
    longint acc [LN];
    longint p;
    logic [LN*DW-1:0] exp_d;
    logic signed [DW-1:0] av, bv;
    spb = (op == 2) ? 1 : len;
    exp_d = '0;
    @(negedge clk);
    bus.start = 1'b1; bus.opcode = 2'(op); bus.acc_len = CW'(len); bus.n_blk = CW'(nblk);
    bus.shift = SW'(sh); bus.sat_en = sat;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 0; k < nblk; k++) begin
      for (int s = 0; s < spb; s++) begin
        repeat ($urandom_range(gap_max, 0)) @(negedge clk);
        for (int l = 0; l < LN; l++) begin
          av = rnd_data ? DW'($urandom) : a_fix[l];
          bv = rnd_data ? DW'($urandom) : b_fix[l];
          bus.a_in[l*DW +: DW] = av;
          bus.b_in[l*DW +: DW] = bv;
          p = longint'(av) * longint'(bv);
          if (op == 1) p = -p;
          acc[l] = (s == 0) ? p : acc[l] + p;
          exp_d[l*DW +: DW] = post(acc[l], sh, sat);
        end
        if (poke && k == 0 && s == 1) begin
          bus.start = 1'b1; bus.opcode = 2'd2; bus.acc_len = 1; bus.n_blk = 1;
        end
        bus.in_valid = 1'b1;
        if (s == spb - 1) exp_q.push_back('{exp_d, (k == nblk - 1)});
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.start = 1'b0;
      end
    end
    if (lat) begin
      check("busy_low_after_last", bus.busy, 0);
      @(negedge clk);
      check("latency_not_early_t2", bus.out_valid, 0);
      @(negedge clk);
      check("latency_not_early_t3", bus.out_valid, 0);
      @(negedge clk);
      check("latency_out_valid_t4", bus.out_valid, 1);
      check("latency_done_t4", bus.done, 1);
      bus.start = 1'b1; bus.opcode = 2'd0; bus.acc_len = 1; bus.n_blk = 1;
      @(negedge clk);
      bus.start = 1'b0;
      check("start_on_done_ignored", bus.busy, 0);
    end
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
    check("results_drained", 64'(exp_q.size()), 0);
    @(negedge clk);
    check("idle_after_run", bus.busy, 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.opcode = '0; bus.acc_len = '0; bus.n_blk = '0;
    bus.shift = '0; bus.sat_en = 1'b0; bus.in_valid = 1'b0; bus.a_in = '0; bus.b_in = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_done", bus.done, 0);
    check("rst_out_data", bus.out_data, 0);
    rst = 1'b0;

    // Back-to-back MACC block with latency probe
    a_fix = '{1, 2, 3, -4}; b_fix = '{1, 2, 3, -4};
    do_run(0, 3, 1, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1);

    // MSUB with in_valid gaps and a start pulse mid-run
    a_fix = '{5, 5, 5, 5}; b_fix = '{2, 2, 2, 2};
    do_run(1, 2, 2, 0, 1'b1, 2, 1'b0, 1'b1, 1'b0);

    // Rounding in MUL mode
    a_fix = '{7, -7, 7, -7}; b_fix = '{1, 1, 1, 1};
    do_run(2, 1, 2, 1, 1'b0, 1, 1'b0, 1'b0, 1'b0);
    do_run(2, 1, 1, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);

    // Saturation vs truncation
    a_fix = '{32767, 32767, 1, -3}; b_fix = '{32767, -32768, 1, 5};
    do_run(0, 4, 1, 0, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    do_run(0, 4, 1, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);

    // Zero-length configs and in_valid while idle
    @(negedge clk);
    bus.start = 1'b1; bus.acc_len = 0; bus.n_blk = 3;
    @(negedge clk);
    bus.start = 1'b0;
    check("acc_len_zero_ignored", bus.busy, 0);
    bus.start = 1'b1; bus.acc_len = 2; bus.n_blk = 0;
    @(negedge clk);
    bus.start = 1'b0;
    check("n_blk_zero_ignored", bus.busy, 0);
    bus.in_valid = 1'b1;
    repeat (8) @(negedge clk);
    bus.in_valid = 1'b0;
    check("in_valid_idle_ignored", bus.busy, 0);

    // Reset in the middle of a block
    bus.start = 1'b1; bus.opcode = 2'd0; bus.acc_len = 4; bus.n_blk = 2; bus.shift = 0;
    @(negedge clk);
    bus.start = 1'b0;
    check("abort_run_started", bus.busy, 1);
    bus.in_valid = 1'b1; bus.a_in = {4{16'sd9}}; bus.b_in = {4{16'sd9}};
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", bus.busy, 0);
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_done", bus.done, 0);
    check("abort_out_data", bus.out_data, 0);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    repeat (8) @(negedge clk);
    a_fix = '{-2, 3, 100, -1000}; b_fix = '{4, -5, 100, 7};
    do_run(0, 2, 1, 2, 1'b1, 1, 1'b0, 1'b0, 1'b0);

    // Randomized runs
    for (int n = 0; n < 30; n++) begin
      do_run(int'($urandom_range(2, 0)), int'($urandom_range(6, 1)), int'($urandom_range(4, 1)),
             int'($urandom_range(12, 0)), 1'($urandom_range(1, 0)), int'($urandom_range(2, 0)),
             1'b1, 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end
endmodule

`default_nettype wire
